dispatch_queue: RTL and testbench
=================================

// Module: dispatch_queue
// PURPOSE
//  In-order FIFO between rename and the ALU execution buffer; producer side of execution_buffer_ifc.
//  Holds renamed ALU ops and presents the oldest when the buffer has space (eb_full low).
//  On a ROB checkpoint restore, drops every held/incoming op younger than the restored tail.
//  Back-pressures rename with stall.
// PARAMETERS
//  DEPTH  4  queue entries; power of two, >=2
// PORTS
//  clk          in   1    clock; single clock domain
//  rst          in   1    reset; synchronous, active-high
//  rn           in   ifc  execution_buffer_ifc.in from rename (valid + payload)
//  stall        out  1    queue cannot accept rn this cycle
//  eb           out  ifc  execution_buffer_ifc.out to execution buffer
//  eb_full      in   1    execution buffer full; eb transfer does not occur
//  rob_restore  in   1    mispredict restore pulse
//  rob_cp_tail  in   $clog2(`ROB_SIZE)  restored ROB tail (first invalid slot)
//  rob_head     in   $clog2(`ROB_SIZE)  current ROB head (oldest live op)
// BEHAVIOUR
//  - State: mem[DEPTH], rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap mod DEPTH), count ($clog2(DEPTH)+1 bits).
//  - Reset: count=0, rd_ptr=wr_ptr=0, all mem valid=0; eb.valid=0, stall=0 from the first cycle after reset.
//  - stall = (count==DEPTH); a push is never taken while full, even if a pop occurs that cycle.
//  - push = rn.valid & ~stall & ~rob_restore; writes mem[wr_ptr], wr_ptr++. Ops arriving during restore are discarded.
//  - eb.valid = (count!=0) & ~(rob_restore & ~keep(mem[rd_ptr].rob_addr)); eb payload = mem[rd_ptr] fields.
//  - pop = eb.valid & ~eb_full; rd_ptr++.
//  - Latency: push in cycle N -> earliest eb.valid in N+1 (without bypass).
//  - keep(a) = (rob_cp_tail > rob_head) ? (a<rob_cp_tail & a>=rob_head) : (a<rob_cp_tail | a>=rob_head).
//    tail==head keeps everything (ROB full).
//  - Restore: entries are age-ordered, so killed entries form a contiguous youngest suffix.
//    The scan is from rd_ptr over count entries. The first killed index k sets wr_ptr=k and count=k-rd_ptr (mod DEPTH), less 1 if the head is popped the same cycle.
//    If the head itself is killed, no pop happens and the queue empties.
//  - Simultaneous push+pop when not full: count unchanged, both pointers advance.
//  - Count never exceeds DEPTH and never underflows; both are assertion-checked.
//  - rst mid-operation: all in-flight entries discarded, and no eb.valid is issued in the reset cycle.
// CONFIGURATION
//  DISPATCH_BYPASS_EN defined:
//    - when count==0, rn.valid, ~eb_full and ~rob_restore, rn is driven straight onto eb in the same cycle (0 latency) and not enqueued.
//    - if eb_full, the op is enqueued normally.
//  DISPATCH_BYPASS_EN undefined:
//    - every op is registered first (1-cycle minimum latency); eb is driven only from mem.
// STRUCTURE
//  - nand_cpu_pkg: add typedef dq_entry (packed: rob_addr, alu_op, immdt, ra_addr, use_rt, rt_addr, write_dst, rw_addr, rs_addr). AluOp already lives there.
//  - Widths come from `ROB_SIZE / `NUM_D_REG / `NUM_S_REG in nand_cpu.svh.
//  - Sub-module rob_in_window (combinational keep(a) checker), instantiated DEPTH+1 times and reusable by execution_buffer.
//  - FIFO control and the restore-suffix scan stay in dispatch_queue.
// TESTING
//  1. Fill/drain: DEPTH=4, eb_full=1, push rob_addr 0..4 -> 4 accepted, stall=1 on the 5th; release eb_full -> eb emits 0,1,2,3 on consecutive cycles.
//  2. Wrap: 10 push/pop cycles with eb_full=0 -> pointers wrap, order preserved, count stays 1, stall never asserts.
//  3. Restore, no wrap: queue holds rob 5,6,7,8; head=2, cp_tail=7, restore -> 7,8 dropped, count=2, eb shows 5 then 6.
//  4. Restore, wrap: ROB_SIZE=16, head=14, cp_tail=1, queue holds 15,0,1,2 -> 15,0 kept, 1,2 dropped; restore with an rn.valid op present -> op discarded.
//  5. Head killed: queue holds 9, head=3, cp_tail=9, restore with eb_full=0 -> eb.valid=0 that cycle, queue empty next cycle.
//  6. Reset mid-run with 3 entries and eb_full=0 -> eb.valid=0 next cycle, count=0. DISPATCH_BYPASS_EN: empty queue, push rob 4 -> eb.valid=1 with rob 4 in the same cycle.

Source files
------------

// File: rtl/dispatch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_queue_pkg
//  Description : Shared widths, ALU opcode enum and the dispatch-queue entry
//                layout used by rename, dispatch_queue and execution_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package dispatch_queue_pkg;

    // Machine geometry; these mirror the core-wide sizing of the ROB and
    // the destination/source register files.
    localparam int ROB_SIZE  = 16;
    localparam int NUM_D_REG = 8;
    localparam int NUM_S_REG = 8;

    localparam int ROB_AW = $clog2(ROB_SIZE);
    localparam int D_AW   = $clog2(NUM_D_REG);
    localparam int S_AW   = $clog2(NUM_S_REG);
    localparam int IMM_W  = 16;

    typedef logic [ROB_AW-1:0] rob_addr_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SLL  = 3'd5,
        ALU_SRL  = 3'd6,
        ALU_NAND = 3'd7
    } AluOp;

    // One renamed ALU op as held in the queue and handed to the buffer.
    typedef struct packed {
        rob_addr_t         rob_addr;
        AluOp              alu_op;
        logic [IMM_W-1:0]  immdt;
        logic [S_AW-1:0]   ra_addr;
        logic              use_rt;
        logic [S_AW-1:0]   rt_addr;
        logic              write_dst;
        logic [D_AW-1:0]   rw_addr;
        logic [S_AW-1:0]   rs_addr;
    } dq_entry;

endpackage
`default_nettype wire

// File: rtl/dispatch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_queue_if
//  Description : Valid + payload handshake carrying renamed ALU ops
//                (rename -> dispatch queue -> execution buffer).
//  Revision    : 1.0  initial release
// ============================================================================
interface dispatch_queue_if;
    import dispatch_queue_pkg::*;

    logic    valid;
    dq_entry data;

    // Producer side drives valid/data.
    modport master (output valid, output data);
    // Consumer side observes valid/data.
    modport slave  (input  valid, input  data);
endinterface
`default_nettype wire

// File: rtl/dispatch_queue_rob_in_window.sv
`default_nettype none
// ============================================================================
//  Module      : rob_in_window
//  Description : Combinational check that a ROB address lies in the live
//                window [head, cp_tail) of the circular ROB. head == cp_tail
//                means the ROB is full, so every address is kept.
//  Revision    : 1.0  initial release
// ============================================================================
module rob_in_window
    import dispatch_queue_pkg::*;
(
    input  wire rob_addr_t addr,
    input  wire rob_addr_t cp_tail,
    input  wire rob_addr_t head,
    output logic           keep
);

    // Non-wrapped window is a plain range; otherwise it is the union of the
    // two pieces on either side of the wrap point.
    always_comb begin
        if (cp_tail > head)
            keep = (addr < cp_tail) && (addr >= head);
        else
            keep = (addr < cp_tail) || (addr >= head);
    end

endmodule
`default_nettype wire

// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_queue
//  Description : In-order FIFO between rename and the ALU execution buffer.
//                Presents the oldest op whenever the buffer has space, stalls
//                rename when full, and on a ROB checkpoint restore drops the
//                youngest suffix of ops outside the restored ROB window.
//  Options     : DISPATCH_BYPASS_EN - when defined, an op arriving at an empty
//                queue with a ready buffer goes straight to eb (0 latency).
//  Revision    : 1.0  initial release
// ============================================================================
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 4              // power of two, >= 2
)(
    input  wire                  clk,
    input  wire                  rst,
    dispatch_queue_if.slave      rn,
    output logic                 stall,
    dispatch_queue_if.master     eb,
    input  wire                  eb_full,
    input  wire                  rob_restore,
    input  wire rob_addr_t       rob_cp_tail,
    input  wire rob_addr_t       rob_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    dq_entry            mem [DEPTH];
    logic [DEPTH-1:0]   mem_valid;
    logic [DEPTH-1:0]   valid_next;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic [DEPTH-1:0]   keep_vec;
    logic [DEPTH-1:0]   kill_vec;
    logic               head_keep;
    logic               head_killed;
    logic               q_valid;
    logic               bypass;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   keep_len;

    // One window check per slot for the restore scan, plus one on the head.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_keep
            rob_in_window u_slot_win (
                .addr    (mem[gi].rob_addr),
                .cp_tail (rob_cp_tail),
                .head    (rob_head),
                .keep    (keep_vec[gi])
            );
        end
    endgenerate

    rob_in_window u_head_win (
        .addr    (mem[rd_ptr].rob_addr),
        .cp_tail (rob_cp_tail),
        .head    (rob_head),
        .keep    (head_keep)
    );

    assign stall       = (count == CNT_W'(DEPTH));
    assign head_killed = rob_restore & ~head_keep;
    // Reset gates the output so nothing is dispatched during the reset cycle.
    assign q_valid     = (count != '0) & ~head_killed & ~rst;
    assign pop         = q_valid & ~eb_full;
    assign push        = rn.valid & ~stall & ~rob_restore & ~bypass;
    assign kill_vec    = mem_valid & ~keep_vec;

`ifdef DISPATCH_BYPASS_EN
    assign bypass  = (count == '0) & rn.valid & ~eb_full & ~rob_restore & ~rst;
    assign eb.valid = q_valid | bypass;
    assign eb.data  = bypass ? rn.data : mem[rd_ptr];
`else
    assign bypass  = 1'b0;
    assign eb.valid = q_valid;
    assign eb.data  = mem[rd_ptr];
`endif

    // Age-ordered scan from the head: the first out-of-window entry marks
    // the start of the killed suffix, so its offset is the surviving length.
    always_comb begin
        keep_len = count;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < count) && !keep_vec[rd_ptr + PTR_W'(i)])
                keep_len = CNT_W'(i);
        end
    end

    // Per-slot occupancy for the next cycle.
    always_comb begin
        valid_next = mem_valid;
        if (rob_restore)
            valid_next = valid_next & ~kill_vec;
        if (pop)
            valid_next[rd_ptr] = 1'b0;
        if (push)
            valid_next[wr_ptr] = 1'b1;
    end

    // Payload storage; only written on an accepted push.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rn.data;
    end

    // Pointer/count control, including the restore truncation.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            mem_valid <= '0;
        end else begin
            mem_valid <= valid_next;
            if (rob_restore) begin
                wr_ptr <= rd_ptr + PTR_W'(keep_len);
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= keep_len - 1'b1;
                end else begin
                    count  <= keep_len;
                end
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Occupancy sanity: never above DEPTH, never pop empty, never push full.
    a_count_max : assert property (@(posedge clk) disable iff (rst)
                                   count <= CNT_W'(DEPTH));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
                                      pop |-> (count != '0));
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                                     push |-> (count < CNT_W'(DEPTH)));
    a_head_valid : assert property (@(posedge clk) disable iff (rst)
                                    (count != '0) |-> mem_valid[rd_ptr]);

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dispatch_queue
//  Description : Self-checking bench for dispatch_queue (DEPTH=4, ROB_SIZE=16)
//                with a scoreboard of expected eb payloads.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      stall;
    logic      eb_full;
    logic      rob_restore;
    rob_addr_t rob_cp_tail;
    rob_addr_t rob_head;

    dispatch_queue_if rn_if ();
    dispatch_queue_if eb_if ();

    dispatch_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rn          (rn_if),
        .stall       (stall),
        .eb          (eb_if),
        .eb_full     (eb_full),
        .rob_restore (rob_restore),
        .rob_cp_tail (rob_cp_tail),
        .rob_head    (rob_head)
    );

    always #5 clk = ~clk;

    int      checks   = 0;
    int      failures = 0;
    dq_entry sb [$];
    dq_entry exp_e;

    // Distinct, address-derived payload so any field mix-up is visible.
    function automatic dq_entry mk(input int a);
        dq_entry     e;
        logic [31:0] v;
        v           = a;
        e.rob_addr  = v[ROB_AW-1:0];
        e.alu_op    = AluOp'(v[2:0]);
        e.immdt     = 16'(v * 37 + 5);
        e.ra_addr   = v[S_AW-1:0];
        e.use_rt    = v[0];
        e.rt_addr   = S_AW'(v + 32'd1);
        e.write_dst = ~v[0];
        e.rw_addr   = D_AW'(v + 32'd2);
        e.rs_addr   = S_AW'(v + 32'd3);
        return e;
    endfunction

    // Reference ROB window test written from the keep() definition.
    function automatic bit tb_keep(input rob_addr_t a, input rob_addr_t t, input rob_addr_t h);
        if (t == h) return 1'b1;
        if (t > h)  return (a < t) && (a >= h);
        return (a < t) || (a >= h);
    endfunction

    // Drop the youngest expected entries from the first one outside the window.
    task automatic sb_restore(input rob_addr_t t, input rob_addr_t h);
        for (int i = 0; i < sb.size(); i++) begin
            if (!tb_keep(sb[i].rob_addr, t, h)) begin
                while (sb.size() > i) void'(sb.pop_back());
                break;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        rn_if.valid = 1'b0;
        rn_if.data  = '0;
        eb_full     = 1'b1;
        rob_restore = 1'b0;
        rob_cp_tail = '0;
        rob_head    = '0;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic push_full(input int a);
        rn_if.valid = 1'b1;
        rn_if.data  = mk(a);
        sb.push_back(mk(a));
        tick();
        rn_if.valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (eb_if.valid !== 1'b0) begin
            failures++; $display("FAIL reset_eb_valid: got %b want 0", eb_if.valid);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL reset_stall: got %b want 0", stall);
        end
        checks++;
        if (dut.count !== 3'd0) begin
            failures++; $display("FAIL reset_count: got %0d want 0", dut.count);
        end
        tick();
    endtask

    task automatic test_fill_drain();
        do_reset();
        eb_full = 1'b1;
        for (int a = 0; a < 5; a++) begin
            rn_if.valid = 1'b1;
            rn_if.data  = mk(a);
            @(negedge clk);
            checks++;
            if (stall !== (a == 4)) begin
                failures++; $display("FAIL fill_stall[%0d]: got %b want %b", a, stall, (a == 4));
            end
            if (a < 4) sb.push_back(mk(a));
            tick();
        end
        rn_if.valid = 1'b0;
        eb_full     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (eb_if.valid !== 1'b1) begin
                failures++; $display("FAIL drain_valid[%0d]: got %b want 1", i, eb_if.valid);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL drain_data[%0d]: got %h want <none>", i, eb_if.data);
            end else begin
                exp_e = sb.pop_front();
                if (eb_if.data !== exp_e) begin
                    failures++; $display("FAIL drain_data[%0d]: got %h want %h", i, eb_if.data, exp_e);
                end
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (eb_if.valid !== 1'b0) begin
            failures++; $display("FAIL drain_empty: got %b want 0", eb_if.valid);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        eb_full = 1'b1;
        push_full(0);
        eb_full = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            rn_if.valid = 1'b1;
            rn_if.data  = mk(i);
            @(negedge clk);
            checks++;
            if ((stall !== 1'b0) || (dut.count !== 3'd1)) begin
                failures++; $display("FAIL wrap_occ[%0d]: got stall=%b count=%0d want stall=0 count=1", i, stall, dut.count);
            end
            checks++;
            exp_e = sb.pop_front();
            if ((eb_if.valid !== 1'b1) || (eb_if.data !== exp_e)) begin
                failures++; $display("FAIL wrap_data[%0d]: got v=%b %h want v=1 %h", i, eb_if.valid, eb_if.data, exp_e);
            end
            sb.push_back(mk(i));
            tick();
        end
        rn_if.valid = 1'b0;
        @(negedge clk);
        checks++;
        exp_e = sb.pop_front();
        if ((eb_if.valid !== 1'b1) || (eb_if.data !== exp_e)) begin
            failures++; $display("FAIL wrap_last: got v=%b %h want v=1 %h", eb_if.valid, eb_if.data, exp_e);
        end
        tick();
        @(negedge clk);
        checks++;
        if (eb_if.valid !== 1'b0) begin
            failures++; $display("FAIL wrap_empty: got %b want 0", eb_if.valid);
        end
    endtask

    task automatic test_restore_no_wrap();
        do_reset();
        eb_full = 1'b1;
        for (int a = 5; a <= 8; a++) push_full(a);
        rob_head    = 4'd2;
        rob_cp_tail = 4'd7;
        rob_restore = 1'b1;
        @(negedge clk);
        checks++;
        if ((eb_if.valid !== 1'b1) || (eb_if.data !== sb[0]) || (stall !== 1'b1)) begin
            failures++; $display("FAIL rnw_restore_cycle: got v=%b %h stall=%b want v=1 %h stall=1", eb_if.valid, eb_if.data, stall, sb[0]);
        end
        sb_restore(rob_cp_tail, rob_head);
        tick();
        rob_restore = 1'b0;
        eb_full     = 1'b0;
        @(negedge clk);
        checks++;
        if ((dut.count !== 3'd2) || (stall !== 1'b0)) begin
            failures++; $display("FAIL rnw_count: got count=%0d stall=%b want count=2 stall=0", dut.count, stall);
        end
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            exp_e = sb.pop_front();
            if ((eb_if.valid !== 1'b1) || (eb_if.data !== exp_e)) begin
                failures++; $display("FAIL rnw_data[%0d]: got v=%b %h want v=1 %h", i, eb_if.valid, eb_if.data, exp_e);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (eb_if.valid !== 1'b0) begin
            failures++; $display("FAIL rnw_empty: got %b want 0", eb_if.valid);
        end
    endtask

    task automatic test_restore_wrap();
        do_reset();
        rob_head    = 4'd14;
        rob_cp_tail = 4'd1;
        eb_full     = 1'b1;
        push_full(15);
        push_full(0);
        push_full(1);
        push_full(2);
        rob_restore = 1'b1;
        eb_full     = 1'b0;
        rn_if.valid = 1'b1;
        rn_if.data  = mk(3);
        @(negedge clk);
        checks++;
        exp_e = sb.pop_front();
        if ((eb_if.valid !== 1'b1) || (eb_if.data !== exp_e)) begin
            failures++; $display("FAIL rw_head_pop: got v=%b %h want v=1 %h", eb_if.valid, eb_if.data, exp_e);
        end
        sb_restore(rob_cp_tail, rob_head);
        tick();
        rob_restore = 1'b0;
        rn_if.valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.count !== 3'd1) begin
            failures++; $display("FAIL rw_count: got %0d want 1", dut.count);
        end
        checks++;
        exp_e = sb.pop_front();
        if ((eb_if.valid !== 1'b1) || (eb_if.data !== exp_e)) begin
            failures++; $display("FAIL rw_data: got v=%b %h want v=1 %h", eb_if.valid, eb_if.data, exp_e);
        end
        tick();
        @(negedge clk);
        checks++;
        if ((eb_if.valid !== 1'b0) || (dut.count !== 3'd0)) begin
            failures++; $display("FAIL rw_empty: got v=%b count=%0d want v=0 count=0", eb_if.valid, dut.count);
        end
    endtask

    task automatic test_head_killed();
        do_reset();
        eb_full = 1'b1;
        push_full(9);
        rob_head    = 4'd3;
        rob_cp_tail = 4'd9;
        rob_restore = 1'b1;
        eb_full     = 1'b0;
        rn_if.valid = 1'b1;
        rn_if.data  = mk(4);
        @(negedge clk);
        checks++;
        if (eb_if.valid !== 1'b0) begin
            failures++; $display("FAIL hk_restore_valid: got %b want 0", eb_if.valid);
        end
        sb_restore(rob_cp_tail, rob_head);
        tick();
        rob_restore = 1'b0;
        rn_if.valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((eb_if.valid !== 1'b0) || (dut.count !== 3'd0) || (sb.size() != 0)) begin
            failures++; $display("FAIL hk_empty: got v=%b count=%0d sb=%0d want v=0 count=0 sb=0", eb_if.valid, dut.count, sb.size());
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        eb_full = 1'b1;
        push_full(1);
        push_full(2);
        push_full(3);
        eb_full = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        checks++;
        if (eb_if.valid !== 1'b0) begin
            failures++; $display("FAIL rst_cycle_valid: got %b want 0", eb_if.valid);
        end
        tick();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if ((eb_if.valid !== 1'b0) || (dut.count !== 3'd0) || (stall !== 1'b0)) begin
            failures++; $display("FAIL rst_after: got v=%b count=%0d stall=%b want v=0 count=0 stall=0", eb_if.valid, dut.count, stall);
        end
        tick();
    endtask

`ifdef DISPATCH_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        eb_full     = 1'b0;
        rn_if.valid = 1'b1;
        rn_if.data  = mk(4);
        @(negedge clk);
        checks++;
        if ((eb_if.valid !== 1'b1) || (eb_if.data !== mk(4))) begin
            failures++; $display("FAIL byp_same_cycle: got v=%b %h want v=1 %h", eb_if.valid, eb_if.data, mk(4));
        end
        tick();
        rn_if.valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((eb_if.valid !== 1'b0) || (dut.count !== 3'd0)) begin
            failures++; $display("FAIL byp_not_enq: got v=%b count=%0d want v=0 count=0", eb_if.valid, dut.count);
        end
        eb_full     = 1'b1;
        rn_if.valid = 1'b1;
        rn_if.data  = mk(6);
        @(negedge clk);
        checks++;
        if (eb_if.valid !== 1'b0) begin
            failures++; $display("FAIL byp_full_valid: got %b want 0", eb_if.valid);
        end
        tick();
        rn_if.valid = 1'b0;
        eb_full     = 1'b0;
        @(negedge clk);
        checks++;
        if ((eb_if.valid !== 1'b1) || (eb_if.data !== mk(6))) begin
            failures++; $display("FAIL byp_full_enq: got v=%b %h want v=1 %h", eb_if.valid, eb_if.data, mk(6));
        end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_restore_no_wrap();
        test_restore_wrap();
        test_head_killed();
        test_reset_mid_run();
`ifdef DISPATCH_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
